// File: rtl/sv_motor_ctrl_if.sv
// Signal bundle between the debounced control front end, the position sequencer and the duty path.
interface sv_motor_ctrl_if;
    logic       inc;
    logic       dec;
    logic [1:0] speed;
    logic       mode;
    logic [7:0] deg;
    logic       frame_start;
    logic       at_min;
    logic       at_max;
    logic       sweeping;

    modport slave (
        input  inc, dec, speed, mode,
        output deg, frame_start, at_min, at_max, sweeping
    );

    modport master (
        output inc, dec, speed, mode,
        input  deg, frame_start, at_min, at_max, sweeping
    );
endinterface

// File: rtl/sv_motor_ctrl.sv
// Frame-synchronous servo position sequencer: owns the PWM frame timebase and moves deg
// only on frame boundaries, either from manual step requests or an automatic ramp-hold sweep.
module sv_motor_ctrl #(
    parameter int PERIOD_NUM  = 999999,
    parameter int DEG_MIN     = 0,
    parameter int DEG_MAX     = 180,
    parameter int DEG_RST     = 90,
    parameter int HOLD_FRAMES = 25
) (
    input  logic            clk,
    input  logic            rst,
    sv_motor_ctrl_if.slave  bus
);

    localparam int              HOLD_W    = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_FRAMES - 1);
    localparam logic [7:0]      MIN8      = 8'(DEG_MIN);
    localparam logic [7:0]      MAX8      = 8'(DEG_MAX);
    localparam logic [7:0]      RST8      = 8'(DEG_RST);
    localparam logic [19:0]     LAST_CNT  = 20'(PERIOD_NUM);

    typedef enum logic [2:0] {
        MANUAL,
        SW_UP,
        SW_HOLD_HI,
        SW_DOWN,
        SW_HOLD_LO
    } state_t;

    state_t            state, state_nxt;
    logic [19:0]       cnt;
    logic [7:0]        deg_q, deg_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
    logic              pend_inc, pend_dec;
    logic              frame_start_q;
    logic              boundary;
    logic [8:0]        step;
    logic [7:0]        deg_up, deg_down;

    function automatic logic [8:0] step_of(input logic [1:0] s);
        logic [8:0] r;
        case (s)
            2'b00:   r = 9'd1;
            2'b01:   r = 9'd2;
            2'b10:   r = 9'd5;
            default: r = 9'd10;
        endcase
        return r;
    endfunction

    // 9-bit headroom so large steps clamp at the limits instead of wrapping
    function automatic logic [7:0] sat_up(input logic [7:0] d, input logic [8:0] s);
        logic [8:0] sum;
        sum = {1'b0, d} + s;
        if (sum > {1'b0, MAX8})
            return MAX8;
        return sum[7:0];
    endfunction

    function automatic logic [7:0] sat_down(input logic [7:0] d, input logic [8:0] s);
        if ({1'b0, d} < ({1'b0, MIN8} + s))
            return MIN8;
        return d - s[7:0];
    endfunction

    assign boundary = (cnt == LAST_CNT);
    assign step     = step_of(bus.speed);
    assign deg_up   = sat_up(deg_q, step);
    assign deg_down = sat_down(deg_q, step);

    always_comb begin
        state_nxt = state;
        deg_nxt   = deg_q;
        hold_nxt  = hold_cnt;
        case (state)
            MANUAL: begin
                if (bus.mode)
                    state_nxt = (deg_q == MAX8) ? SW_DOWN : SW_UP;
                else if (pend_inc && !pend_dec)
                    deg_nxt = deg_up;
                else if (pend_dec && !pend_inc)
                    deg_nxt = deg_down;
            end
            SW_UP: begin
                if (!bus.mode) begin
                    state_nxt = MANUAL;
                end else begin
                    deg_nxt = deg_up;
                    if (deg_up == MAX8) begin
                        state_nxt = SW_HOLD_HI;
                        hold_nxt  = HOLD_LOAD;
                    end
                end
            end
            SW_DOWN: begin
                if (!bus.mode) begin
                    state_nxt = MANUAL;
                end else begin
                    deg_nxt = deg_down;
                    if (deg_down == MIN8) begin
                        state_nxt = SW_HOLD_LO;
                        hold_nxt  = HOLD_LOAD;
                    end
                end
            end
            // Expiry steps on the same boundary so the dwell lasts exactly HOLD_FRAMES frames
            SW_HOLD_HI: begin
                if (!bus.mode) begin
                    state_nxt = MANUAL;
                end else if (hold_cnt == '0) begin
                    deg_nxt   = deg_down;
                    state_nxt = (deg_down == MIN8) ? SW_HOLD_LO : SW_DOWN;
                    hold_nxt  = HOLD_LOAD;
                end else begin
                    hold_nxt = hold_cnt - 1'b1;
                end
            end
            SW_HOLD_LO: begin
                if (!bus.mode) begin
                    state_nxt = MANUAL;
                end else if (hold_cnt == '0) begin
                    deg_nxt   = deg_up;
                    state_nxt = (deg_up == MAX8) ? SW_HOLD_HI : SW_UP;
                    hold_nxt  = HOLD_LOAD;
                end else begin
                    hold_nxt = hold_cnt - 1'b1;
                end
            end
            default: state_nxt = MANUAL;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt           <= '0;
            deg_q         <= RST8;
            frame_start_q <= 1'b0;
            state         <= MANUAL;
            hold_cnt      <= '0;
            pend_inc      <= 1'b0;
            pend_dec      <= 1'b0;
        end else begin
            frame_start_q <= boundary;
            if (boundary) begin
                cnt      <= '0;
                state    <= state_nxt;
                deg_q    <= deg_nxt;
                hold_cnt <= hold_nxt;
                // A request landing on the boundary cycle itself carries into the next frame
                pend_inc <= bus.inc && (state == MANUAL);
                pend_dec <= bus.dec && (state == MANUAL);
            end else begin
                cnt <= cnt + 20'd1;
                if (state == MANUAL) begin
                    if (bus.inc)
                        pend_inc <= 1'b1;
                    if (bus.dec)
                        pend_dec <= 1'b1;
                end
            end
        end
    end

    assign bus.deg         = deg_q;
    assign bus.frame_start = frame_start_q;
    assign bus.at_min      = (deg_q == MIN8);
    assign bus.at_max      = (deg_q == MAX8);
    assign bus.sweeping    = (state != MANUAL);

endmodule

// File: tb/tb_sv_motor_ctrl.sv
// Directed bench for sv_motor_ctrl: expected per-frame positions are queued ahead and checked
// at each frame_start pulse.
module tb_sv_motor_ctrl;

    localparam int PERIOD_NUM  = 9;
    localparam int HOLD_FRAMES = 2;
    localparam int DEG_MIN     = 0;
    localparam int DEG_MAX     = 180;
    localparam int DEG_RST     = 90;
    localparam int FRAME_CYC   = PERIOD_NUM + 1;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    sv_motor_ctrl_if bus();

    sv_motor_ctrl #(
        .PERIOD_NUM  (PERIOD_NUM),
        .DEG_MIN     (DEG_MIN),
        .DEG_MAX     (DEG_MAX),
        .DEG_RST     (DEG_RST),
        .HOLD_FRAMES (HOLD_FRAMES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [7:0] deg;
        logic       sw;
    } exp_t;

    exp_t sb[$];
    int   tests    = 0;
    int   fails    = 0;
    int   fnum     = 0;
    int   last_deg = DEG_RST;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        tests++;
        assert (obs === req) else begin
            fails++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, req);
        end
    endtask

    task automatic push(input int d, input bit sw);
        exp_t e;
        e.deg = d[7:0];
        e.sw  = sw;
        sb.push_back(e);
    endtask

    task automatic frame_check();
        exp_t e;
        fnum++;
        tests++;
        assert (sb.size() != 0) else begin
            fails++;
            $error("FAIL sb_underflow f%0d: observed depth %0d required >0", fnum, sb.size());
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check($sformatf("deg f%0d", fnum), bus.deg, e.deg);
            check($sformatf("sweeping f%0d", fnum), bus.sweeping, e.sw);
            check($sformatf("at_min f%0d", fnum), bus.at_min, (int'(e.deg) == DEG_MIN));
            check($sformatf("at_max f%0d", fnum), bus.at_max, (int'(e.deg) == DEG_MAX));
            last_deg = int'(e.deg);
        end
    endtask

    // exp_cyc > 0 also checks the distance (in cycles) to the next frame_start
    task automatic next_frame(input int exp_cyc);
        int n;
        bit seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 4 * FRAME_CYC) begin
            @(negedge clk);
            n++;
            seen = bus.frame_start;
        end
        tests++;
        assert (seen) else begin
            fails++;
            $error("FAIL frame_timeout f%0d: observed no frame_start in %0d cycles", fnum + 1, n);
        end
        if (seen) begin
            if (exp_cyc > 0)
                check($sformatf("period f%0d", fnum + 1), n, exp_cyc);
            frame_check();
        end
    endtask

    task automatic pulse(input bit i, input bit d);
        bus.inc = i;
        bus.dec = d;
        @(negedge clk);
        bus.inc = 1'b0;
        bus.dec = 1'b0;
    endtask

    // Called on a frame_start sample: one request mid-frame, deg must not move before the boundary
    task automatic pulse_frame(input bit i, input bit d);
        repeat (3) @(negedge clk);
        pulse(i, d);
        check($sformatf("mid_hold f%0d", fnum), bus.deg, last_deg);
        next_frame(FRAME_CYC - 4);
    endtask

    initial begin
        rst       = 1'b0;
        bus.inc   = 1'b0;
        bus.dec   = 1'b0;
        bus.speed = 2'b00;
        bus.mode  = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_deg", bus.deg, DEG_RST);
        check("rst_frame_start", bus.frame_start, 0);
        check("rst_sweeping", bus.sweeping, 0);
        check("rst_at_min", bus.at_min, 0);
        check("rst_at_max", bus.at_max, 0);
        rst = 1'b1;

        // Idle frames: position stays at the reset value
        repeat (3) push(90, 0);
        repeat (3) next_frame(FRAME_CYC);

        // Single steps at the different speed codes
        push(91, 0);  pulse_frame(1, 0);
        bus.speed = 2'b10;
        push(96, 0);  pulse_frame(1, 0);
        bus.speed = 2'b01;
        push(94, 0);  pulse_frame(0, 1);

        // Two inc pulses in one frame still make one step
        bus.speed = 2'b11;
        push(104, 0);
        repeat (2) @(negedge clk);
        pulse(1, 0);
        pulse(1, 0);
        next_frame(FRAME_CYC - 4);

        for (int k = 1; k <= 7; k++) begin
            push(104 + 10 * k, 0);
            pulse_frame(1, 0);
        end
        bus.speed = 2'b00;
        push(175, 0); pulse_frame(1, 0);

        // Upper clamp
        bus.speed = 2'b11;
        push(180, 0); pulse_frame(1, 0);
        push(180, 0); pulse_frame(1, 0);

        // inc and dec together cancel
        push(180, 0); pulse_frame(1, 1);

        // Down to the lower clamp and one more dec
        for (int k = 1; k <= 18; k++) begin
            push(180 - 10 * k, 0);
            pulse_frame(0, 1);
        end
        push(0, 0);   pulse_frame(0, 1);

        // inc on the boundary cycle lands one frame later
        bus.speed = 2'b00;
        repeat (FRAME_CYC - 1) @(negedge clk);
        bus.inc = 1'b1;
        @(negedge clk);
        bus.inc = 1'b0;
        check("bnd_frame_start", bus.frame_start, 1);
        push(0, 0);
        frame_check();
        push(1, 0);
        next_frame(FRAME_CYC);

        // Reset in the middle of a frame
        repeat (4) @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_deg", bus.deg, DEG_RST);
        check("midrst_frame_start", bus.frame_start, 0);
        @(negedge clk);
        rst = 1'b1;
        push(90, 0);
        next_frame(FRAME_CYC);

        // Auto sweep from 90 at 10 degrees per frame; inc pulses must be ignored
        bus.mode  = 1'b1;
        bus.speed = 2'b11;
        push(90, 1);
        for (int d = 100; d <= 180; d += 10) push(d, 1);
        push(180, 1);
        for (int d = 170; d >= 0; d -= 10) push(d, 1);
        push(0, 1);
        push(10, 1);
        push(20, 1);
        for (int f = 0; f < 32; f++) begin
            if (f % 3 == 1)
                pulse_frame(1, 0);
            else
                next_frame(FRAME_CYC);
        end

        for (int d = 30; d <= 180; d += 10) push(d, 1);
        push(180, 1);
        for (int d = 170; d >= 120; d -= 10) push(d, 1);
        for (int f = 0; f < 23; f++) begin
            if (f % 4 == 2)
                pulse_frame(1, 0);
            else
                next_frame(FRAME_CYC);
        end

        // Leave the sweep while ramping down at 120
        repeat (3) @(negedge clk);
        bus.mode = 1'b0;
        push(120, 0);
        next_frame(FRAME_CYC - 3);
        push(120, 0);
        next_frame(FRAME_CYC);
        push(130, 0);
        pulse_frame(1, 0);

        check("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
